// File: rtl/ifft8_if.sv
// Bus bundle for the ifft8 inverse FFT: write/start/ready handshake, state
// readback, eight complex input bins and eight complex output samples.
interface ifft8_if #(
  parameter int DW = 16
);
  // Handshake: in IDLE a write pulse captures x*; in LOAD, start (level-held)
  // launches the transform; ready stays high in DONE, where y* are valid.
  // Dropping start in DONE returns to IDLE. y* hold their last result.
  logic          write;
  logic          start;
  logic          ready;
  logic [1:0]    state;
  logic [DW-1:0] x0r, x1r, x2r, x3r, x4r, x5r, x6r, x7r;
  logic [DW-1:0] x0i, x1i, x2i, x3i, x4i, x5i, x6i, x7i;
  logic [DW-1:0] y0r, y1r, y2r, y3r, y4r, y5r, y6r, y7r;
  logic [DW-1:0] y0i, y1i, y2i, y3i, y4i, y5i, y6i, y7i;

  modport master (
    output write, start,
    output x0r, x1r, x2r, x3r, x4r, x5r, x6r, x7r,
    output x0i, x1i, x2i, x3i, x4i, x5i, x6i, x7i,
    input  ready, state,
    input  y0r, y1r, y2r, y3r, y4r, y5r, y6r, y7r,
    input  y0i, y1i, y2i, y3i, y4i, y5i, y6i, y7i
  );

  modport slave (
    input  write, start,
    input  x0r, x1r, x2r, x3r, x4r, x5r, x6r, x7r,
    input  x0i, x1i, x2i, x3i, x4i, x5i, x6i, x7i,
    output ready, state,
    output y0r, y1r, y2r, y3r, y4r, y5r, y6r, y7r,
    output y0i, y1i, y2i, y3i, y4i, y5i, y6i, y7i
  );
endinterface

// File: rtl/ifft8.sv
// 8-point radix-2 DIT inverse FFT, Q8.8 complex, one shared butterfly,
// 12 butterfly cycles per transform, each stage halved for a 1/8 overall scale.
module ifft8 #(
  parameter int DW   = 16,
  parameter int FRAC = 8
) (
  input  logic    clk,
  input  logic    rst,
  ifft8_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int PW = 2 * DW;   // product width
  localparam int TW = DW + 2;   // butterfly intermediate width

  state_t               state_q, state_d;
  logic [1:0]           stage_q, stage_d;
  logic [1:0]           bf_q, bf_d;
  logic                 ready_q, ready_d;
  logic signed [DW-1:0] wr_q [8];
  logic signed [DW-1:0] wi_q [8];
  logic signed [DW-1:0] wr_d [8];
  logic signed [DW-1:0] wi_d [8];
  logic signed [DW-1:0] yr_q [8];
  logic signed [DW-1:0] yi_q [8];
  logic signed [DW-1:0] yr_d [8];
  logic signed [DW-1:0] yi_d [8];
  logic signed [DW-1:0] xr [8];
  logic signed [DW-1:0] xi [8];

  assign xr[0] = bus.x0r;  assign xi[0] = bus.x0i;
  assign xr[1] = bus.x1r;  assign xi[1] = bus.x1i;
  assign xr[2] = bus.x2r;  assign xi[2] = bus.x2i;
  assign xr[3] = bus.x3r;  assign xi[3] = bus.x3i;
  assign xr[4] = bus.x4r;  assign xi[4] = bus.x4i;
  assign xr[5] = bus.x5r;  assign xi[5] = bus.x5i;
  assign xr[6] = bus.x6r;  assign xi[6] = bus.x6i;
  assign xr[7] = bus.x7r;  assign xi[7] = bus.x7i;

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  // Butterfly operand selection and twiddle lookup for (stage_q, bf_q)
  logic [2:0]           a_idx, b_idx;
  logic [1:0]           tw_k;
  logic signed [DW-1:0] op_ar, op_ai, op_br, op_bi, tw_r, tw_i;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic [PW:0]          sum_r, sum_i;
  logic [TW-1:0]        t_r, t_i, s_ar, s_ai, s_br, s_bi;
  logic signed [DW-1:0] na_r, na_i, nb_r, nb_i;
  logic                 unused_bits;

  always_comb begin
    a_idx = {1'b0, bf_q};
    b_idx = {1'b1, bf_q};
    tw_k  = bf_q;
    case (stage_q)
      2'd0: begin
        a_idx = {bf_q, 1'b0};
        b_idx = {bf_q, 1'b1};
        tw_k  = 2'd0;
      end
      2'd1: begin
        a_idx = {bf_q[1], 1'b0, bf_q[0]};
        b_idx = {bf_q[1], 1'b1, bf_q[0]};
        tw_k  = {bf_q[0], 1'b0};
      end
      default: ;
    endcase

    // Conjugate twiddles e^{+j*2*pi*k/8} in Q8.8
    case (tw_k)
      2'd0:    begin tw_r = 16'sd256;  tw_i = 16'sd0;   end
      2'd1:    begin tw_r = 16'sd181;  tw_i = 16'sd181; end
      2'd2:    begin tw_r = 16'sd0;    tw_i = 16'sd256; end
      default: begin tw_r = -16'sd181; tw_i = 16'sd181; end
    endcase

    op_ar = wr_q[a_idx];
    op_ai = wi_q[a_idx];
    op_br = wr_q[b_idx];
    op_bi = wi_q[b_idx];

    p_rr  = tw_r * op_br;
    p_ii  = tw_i * op_bi;
    p_ri  = tw_r * op_bi;
    p_ir  = tw_i * op_br;
    sum_r = {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii};
    sum_i = {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir};

    // Arithmetic shift by FRAC, keep TW bits
    t_r = sum_r[TW-1+FRAC:FRAC];
    t_i = sum_i[TW-1+FRAC:FRAC];

    s_ar = {{2{op_ar[DW-1]}}, op_ar} + t_r;
    s_ai = {{2{op_ai[DW-1]}}, op_ai} + t_i;
    s_br = {{2{op_ar[DW-1]}}, op_ar} - t_r;
    s_bi = {{2{op_ai[DW-1]}}, op_ai} - t_i;

    // >>>1 then truncate to DW bits; wraps on overflow by design
    na_r = s_ar[DW:1];
    na_i = s_ai[DW:1];
    nb_r = s_br[DW:1];
    nb_i = s_bi[DW:1];
  end

  assign unused_bits = ^{sum_r[PW:TW+FRAC], sum_r[FRAC-1:0],
                         sum_i[PW:TW+FRAC], sum_i[FRAC-1:0],
                         s_ar[TW-1], s_ar[0], s_ai[TW-1], s_ai[0],
                         s_br[TW-1], s_br[0], s_bi[TW-1], s_bi[0]};

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bf_d    = bf_q;
    ready_d = ready_q;
    for (int i = 0; i < 8; i++) begin
      wr_d[i] = wr_q[i];
      wi_d[i] = wi_q[i];
      yr_d[i] = yr_q[i];
      yi_d[i] = yi_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.write) begin
          for (int k = 0; k < 8; k++) begin
            wr_d[bitrev3(3'(k))] = xr[k];
            wi_d[bitrev3(3'(k))] = xi[k];
          end
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.start) begin
          state_d = ST_CALC;
          stage_d = 2'd0;
          bf_d    = 2'd0;
        end else if (bus.write) begin
          for (int k = 0; k < 8; k++) begin
            wr_d[bitrev3(3'(k))] = xr[k];
            wi_d[bitrev3(3'(k))] = xi[k];
          end
        end
      end
      ST_CALC: begin
        wr_d[a_idx] = na_r;
        wi_d[a_idx] = na_i;
        wr_d[b_idx] = nb_r;
        wi_d[b_idx] = nb_i;
        bf_d        = bf_q + 2'd1;
        if (bf_q == 2'd3) begin
          stage_d = stage_q + 2'd1;
        end
        // Last butterfly: publish including this cycle's result
        if ((stage_q == 2'd2) && (bf_q == 2'd3)) begin
          for (int i = 0; i < 8; i++) begin
            yr_d[i] = wr_d[i];
            yi_d[i] = wi_d[i];
          end
          ready_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: begin
        if (!bus.start) begin
          ready_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      stage_q <= 2'd0;
      bf_q    <= 2'd0;
      ready_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        wr_q[i] <= '0;
        wi_q[i] <= '0;
        yr_q[i] <= '0;
        yi_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      bf_q    <= bf_d;
      ready_q <= ready_d;
      for (int i = 0; i < 8; i++) begin
        wr_q[i] <= wr_d[i];
        wi_q[i] <= wi_d[i];
        yr_q[i] <= yr_d[i];
        yi_q[i] <= yi_d[i];
      end
    end
  end

  assign bus.ready = ready_q;
  assign bus.state = state_q;
  assign bus.y0r = yr_q[0];  assign bus.y0i = yi_q[0];
  assign bus.y1r = yr_q[1];  assign bus.y1i = yi_q[1];
  assign bus.y2r = yr_q[2];  assign bus.y2i = yi_q[2];
  assign bus.y3r = yr_q[3];  assign bus.y3i = yi_q[3];
  assign bus.y4r = yr_q[4];  assign bus.y4i = yi_q[4];
  assign bus.y5r = yr_q[5];  assign bus.y5i = yi_q[5];
  assign bus.y6r = yr_q[6];  assign bus.y6i = yi_q[6];
  assign bus.y7r = yr_q[7];  assign bus.y7i = yi_q[7];

endmodule

// File: tb/tb_ifft8.sv
// Directed + random bench for ifft8 against a stage-loop reference IFFT with
// trigonometric twiddles, plus exact and tolerance checks on known transforms.
module tb_ifft8;
  localparam int DW = 16;
  localparam int W  = 16;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp [16];
  logic [W-1:0] x_drv [16];
  logic [W-1:0] y_obs [16];
  int           vr [8];
  int           vi [8];
  int           gr [8];
  int           gi [8];

  always #5 clk = ~clk;

  ifft8_if #(.DW(DW)) bus ();
  ifft8 #(.DW(DW), .FRAC(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  assign bus.x0r = x_drv[0];  assign bus.x0i = x_drv[1];
  assign bus.x1r = x_drv[2];  assign bus.x1i = x_drv[3];
  assign bus.x2r = x_drv[4];  assign bus.x2i = x_drv[5];
  assign bus.x3r = x_drv[6];  assign bus.x3i = x_drv[7];
  assign bus.x4r = x_drv[8];  assign bus.x4i = x_drv[9];
  assign bus.x5r = x_drv[10]; assign bus.x5i = x_drv[11];
  assign bus.x6r = x_drv[12]; assign bus.x6i = x_drv[13];
  assign bus.x7r = x_drv[14]; assign bus.x7i = x_drv[15];
  assign y_obs[0]  = bus.y0r; assign y_obs[1]  = bus.y0i;
  assign y_obs[2]  = bus.y1r; assign y_obs[3]  = bus.y1i;
  assign y_obs[4]  = bus.y2r; assign y_obs[5]  = bus.y2i;
  assign y_obs[6]  = bus.y3r; assign y_obs[7]  = bus.y3i;
  assign y_obs[8]  = bus.y4r; assign y_obs[9]  = bus.y4i;
  assign y_obs[10] = bus.y5r; assign y_obs[11] = bus.y5i;
  assign y_obs[12] = bus.y6r; assign y_obs[13] = bus.y6i;
  assign y_obs[14] = bus.y7r; assign y_obs[15] = bus.y7i;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input int expv, input int tol);
    n_checks++;
    assert (((obs - expv) <= tol) && ((expv - obs) <= tol)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d +-%0d", tag, obs, expv, tol);
    end
  endtask

  task automatic set_x(input int xr [8], input int xi [8]);
    for (int k = 0; k < 8; k++) begin
      x_drv[2*k]   = W'(xr[k]);
      x_drv[2*k+1] = W'(xi[k]);
    end
  endtask

  // Reference: bit-reversed load, then log2(8) stages of halved butterflies
  // with twiddles rounded from cos/sin, integer floor arithmetic throughout.
  task automatic model_push(input int xr [8], input int xi [8]);
    int  ar [8];
    int  ai [8];
    int  rev, a, b, wr, wi, tr, ti, nar, nai, nbr, nbi;
    real ang;
    for (int k = 0; k < 8; k++) begin
      rev = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
      ar[rev] = xr[k];
      ai[rev] = xi[k];
    end
    for (int span = 1; span < 8; span = span * 2) begin
      for (int g = 0; g < 8; g = g + 2 * span) begin
        for (int j = 0; j < span; j++) begin
          ang = PI * j / span;
          wr  = int'($cos(ang) * 256.0);
          wi  = int'($sin(ang) * 256.0);
          a   = g + j;
          b   = a + span;
          tr  = (wr * ar[b] - wi * ai[b]) >>> 8;
          ti  = (wr * ai[b] + wi * ar[b]) >>> 8;
          nar = (ar[a] + tr) >>> 1;
          nai = (ai[a] + ti) >>> 1;
          nbr = (ar[a] - tr) >>> 1;
          nbi = (ai[a] - ti) >>> 1;
          ar[a] = nar; ai[a] = nai;
          ar[b] = nbr; ai[b] = nbi;
        end
      end
    end
    for (int n = 0; n < 8; n++) begin
      exp_q.push_back(W'(ar[n]));
      exp_q.push_back(W'(ai[n]));
    end
  endtask

  task automatic check_y(input string tag);
    logic [W-1:0] e;
    for (int n = 0; n < 16; n++) begin
      e = exp_q.pop_front();
      last_exp[n] = e;
      chk($sformatf("%s y%0d%s", tag, n / 2, (n % 2) ? "i" : "r"), y_obs[n], e);
    end
  endtask

  task automatic push_last();
    for (int n = 0; n < 16; n++) exp_q.push_back(last_exp[n]);
  endtask

  task automatic run_transform(input string tag, input int xr [8], input int xi [8]);
    set_x(xr, xi);
    bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    chk($sformatf("%s state_load", tag), bus.state, 1);
    bus.start = 1'b1;
    tick();
    chk($sformatf("%s state_calc", tag), bus.state, 2);
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 11) chk($sformatf("%s ready_e11", tag), bus.ready, 0);
    end
    chk($sformatf("%s ready_e12", tag), bus.ready, 1);
    chk($sformatf("%s state_done", tag), bus.state, 3);
    model_push(xr, xi);
    check_y(tag);
    bus.start = 1'b0;
    tick();
    chk($sformatf("%s state_idle", tag), bus.state, 0);
    chk($sformatf("%s ready_low", tag), bus.ready, 0);
  endtask

  task automatic rand_vec();
    for (int k = 0; k < 8; k++) begin
      vr[k] = int'($urandom_range(0, 32766)) - 16383;
      vi[k] = int'($urandom_range(0, 32766)) - 16383;
    end
  endtask

  initial begin
    real re, im;
    bus.write = 1'b0;
    bus.start = 1'b0;
    for (int n = 0; n < 16; n++) x_drv[n] = '0;

    // Reset values
    #12;
    chk("rst state", bus.state, 0);
    chk("rst ready", bus.ready, 0);
    for (int n = 0; n < 16; n++) chk($sformatf("rst y%0d", n), y_obs[n], 0);
    rst = 1'b1;
    tick();

    // Impulse: every output equals 1.0
    for (int k = 0; k < 8; k++) begin vr[k] = 0; vi[k] = 0; end
    vr[0] = 16'h0800;
    run_transform("impulse", vr, vi);
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("impulse const y%0dr", n), y_obs[2*n], 16'h0100);
      chk($sformatf("impulse const y%0di", n), y_obs[2*n+1], 16'h0000);
    end

    // DC: only y0 nonzero
    for (int k = 0; k < 8; k++) begin vr[k] = 16'h0100; vi[k] = 0; end
    run_transform("dc", vr, vi);
    chk("dc const y0r", y_obs[0], 16'h0100);
    for (int n = 1; n < 16; n++) chk($sformatf("dc const y%0d", n), y_obs[n], 0);

    // Tone on bin 1, loaded over a random preload in LOAD
    rand_vec();
    set_x(vr, vi);
    bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    for (int k = 0; k < 8; k++) begin vr[k] = 0; vi[k] = 0; end
    vr[1] = 16'h0800;
    run_transform("tone", vr, vi);
    chk("tone y0r", y_obs[0], 16'h0100);
    chk("tone y0i", y_obs[1], 16'h0000);
    chk("tone y2r", y_obs[4], 16'h0000);
    chk("tone y2i", y_obs[5], 16'h0100);
    chk("tone y4r", y_obs[8], 16'hFF00);
    chk("tone y4i", y_obs[9], 16'h0000);
    chk_near("tone y1r", int'($signed(y_obs[2])), 16'h00B5, 2);
    chk_near("tone y1i", int'($signed(y_obs[3])), 16'h00B5, 2);

    // Round trip: forward DFT of a ramp comes back as the ramp
    for (int k = 0; k < 8; k++) begin
      re = 0.0;
      im = 0.0;
      for (int n = 0; n < 8; n++) begin
        re = re + n * 256.0 * $cos(2.0 * PI * k * n / 8.0);
        im = im - n * 256.0 * $sin(2.0 * PI * k * n / 8.0);
      end
      vr[k] = int'(re);
      vi[k] = int'(im);
    end
    run_transform("ramp", vr, vi);
    for (int n = 0; n < 8; n++) begin
      chk_near($sformatf("ramp y%0dr", n), int'($signed(y_obs[2*n])), n * 256, 4);
      chk_near($sformatf("ramp y%0di", n), int'($signed(y_obs[2*n+1])), 0, 4);
    end

    // Random spectra within the non-overflowing range
    for (int t = 0; t < 6; t++) begin
      rand_vec();
      run_transform($sformatf("rand%0d", t), vr, vi);
    end

    // Reset during the 5th CALC cycle clears everything at once
    rand_vec();
    set_x(vr, vi);
    bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    bus.start = 1'b1;
    tick();
    for (int e = 1; e <= 4; e++) tick();
    chk("abort pre state", bus.state, 2);
    rst = 1'b0;
    #1;
    chk("abort state", bus.state, 0);
    chk("abort ready", bus.ready, 0);
    for (int n = 0; n < 16; n++) chk($sformatf("abort y%0d", n), y_obs[n], 0);
    bus.start = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin vr[k] = 0; vi[k] = 0; end
    vr[0] = 16'h0800;
    run_transform("post_abort", vr, vi);

    // Handshake corner cases
    bus.start = 1'b1;
    tick();
    chk("hs start_in_idle a", bus.state, 0);
    tick();
    chk("hs start_in_idle b", bus.state, 0);
    rand_vec();
    set_x(vr, vi);
    bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    chk("hs write_start_idle", bus.state, 1);
    tick();
    chk("hs e0 calc", bus.state, 2);
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 6) begin
        push_last();
        check_y("hs midcalc");
      end
      if (e == 11) chk("hs ready_e11", bus.ready, 0);
    end
    chk("hs ready_e12", bus.ready, 1);
    model_push(vr, vi);
    check_y("hs done");
    rand_vec();
    set_x(vr, vi);
    bus.write = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("hs hold state %0d", c), bus.state, 3);
      chk($sformatf("hs hold ready %0d", c), bus.ready, 1);
    end
    bus.write = 1'b0;
    push_last();
    check_y("hs hold");
    bus.start = 1'b0;
    tick();
    chk("hs release state", bus.state, 0);
    chk("hs release ready", bus.ready, 0);
    push_last();
    check_y("hs retained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
